layer_sequencer: RTL and testbench

- Multi-layer run controller that sits between the top-level start/mode/finish pins and the tensor accelerator.
- Replaces the single-shot start/mode/finish hookup: one start_i runs a programmed list of up to MAX_LAYERS layers, each with its own mode.
- Ping-pongs the two InOut SRAM buffers between input and output roles on every layer.
- Supervises each layer with a timeout watchdog.

---
 rtl/layer_sequencer.sv | 155 +++++++++++++++
 tb/tb_layer_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// layer_sequencer: multi-layer run controller for the tensor accelerator.
// One start runs a programmed list of layers. Each layer has its own mode
// from a small table. The two InOut buffers swap roles on every layer, and a
// watchdog supervises each layer while it waits for the accelerator.
module layer_sequencer #(
  parameter int MAX_LAYERS = 16,
  parameter int MODE_W     = 4,
  parameter int IDX_W      = $clog2(MAX_LAYERS),
  parameter int TIMEOUT_W  = 20
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [IDX_W:0]    num_layers_i,
  input  logic              cfg_we_i,
  input  logic [IDX_W-1:0]  cfg_addr_i,
  input  logic [MODE_W-1:0] cfg_mode_i,
  output logic              acc_start_o,
  output logic [MODE_W-1:0] acc_mode_o,
  input  logic              acc_finish_i,
  output logic              buf_sel_o,
  output logic [IDX_W-1:0]  layer_idx_o,
  output logic              busy_o,
  output logic              finish_o,
  output logic              result_buf_o,
  output logic              error_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_NEXT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [IDX_W:0] MAX_CNT = (IDX_W+1)'(MAX_LAYERS);

  state_t                state;
  logic [MODE_W-1:0]     mode_tab [MAX_LAYERS];
  logic [IDX_W:0]        count;
  logic [TIMEOUT_W-1:0]  wd;

  logic                  cfg_open;
  logic                  start_ok;
  logic                  last_layer;
  logic [IDX_W-1:0]      idx_nxt;

  // Decode helpers for the run controller.
  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    cfg_open   = 1'b0;
    start_ok   = 1'b0;
    last_layer = 1'b0;
    idx_nxt    = '0;
    cfg_open   = (state == S_IDLE) || (state == S_ERR);
    start_ok   = (num_layers_i != '0) && (num_layers_i <= MAX_CNT);
    last_layer = ({1'b0, layer_idx_o} == (count - (IDX_W+1)'(1)));
    idx_nxt    = layer_idx_o + IDX_W'(1);
  end

  // The accelerator sees start for exactly the LAUNCH cycle.
  // busy covers the whole active part of a run.
  assign acc_start_o = (state == S_LAUNCH);
  assign busy_o      = (state == S_LAUNCH) || (state == S_WAIT) ||
                       (state == S_NEXT)   || (state == S_DONE);

  // The mode table can only be programmed while no run is active.
  // NOTE: the table is built from flops and must read as zero after reset, so every entry is reset; an SRAM would not be.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < MAX_LAYERS; i++) mode_tab[i] <= '0;
    end else if (cfg_we_i && cfg_open) begin
      mode_tab[cfg_addr_i] <= cfg_mode_i;
    end
  end

  // Run FSM with registered mode, buffer select, index, watchdog and status.
  // NOTE: sequential state uses non-blocking assignments only, so all flops update together at the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      count        <= '0;
      wd           <= '0;
      acc_mode_o   <= '0;
      buf_sel_o    <= 1'b0;
      layer_idx_o  <= '0;
      finish_o     <= 1'b0;
      result_buf_o <= 1'b0;
      error_o      <= 1'b0;
    end else begin
      finish_o <= 1'b0;
      if (abort_i) begin
        // Abort wins over everything. The table and the last result are kept.
        state   <= S_IDLE;
        error_o <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_ERR: begin
            if (start_i) begin
              if (start_ok) begin
                count       <= num_layers_i;
                layer_idx_o <= '0;
                buf_sel_o   <= 1'b0;
                error_o     <= 1'b0;
                // Load the mode before LAUNCH so it is valid alongside the start pulse.
                acc_mode_o  <= mode_tab[0];
                state       <= S_LAUNCH;
              end else begin
                error_o <= 1'b1;
                state   <= S_ERR;
              end
            end
          end
          S_LAUNCH: begin
            wd    <= '0;
            state <= S_WAIT;
          end
          S_WAIT: begin
            // A finish in the saturation cycle still completes the layer.
            if (acc_finish_i) begin
              state <= S_NEXT;
            end else if (&wd) begin
              error_o <= 1'b1;
              state   <= S_ERR;
            end else begin
              wd <= wd + TIMEOUT_W'(1);
            end
          end
          S_NEXT: begin
            if (last_layer) begin
              finish_o     <= 1'b1;
              result_buf_o <= buf_sel_o;
              state        <= S_DONE;
            end else begin
              layer_idx_o <= idx_nxt;
              buf_sel_o   <= ~buf_sel_o;
              acc_mode_o  <= mode_tab[idx_nxt];
              state       <= S_LAUNCH;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed bench with a scoreboard of expected
// accelerator starts and run completions. A negedge monitor checks them.
// A second instance with a 4-bit watchdog exercises the timeout path.
module tb_layer_sequencer;

  localparam int MAXL  = 16;
  localparam int MW    = 4;
  localparam int IW    = 4;

  logic          clk;
  logic          rstn;
  logic          start_i;
  logic          abort_i;
  logic [IW:0]   num_layers_i;
  logic          cfg_we_i;
  logic [IW-1:0] cfg_addr_i;
  logic [MW-1:0] cfg_mode_i;
  logic          acc_start_o;
  logic [MW-1:0] acc_mode_o;
  logic          acc_finish_i;
  logic          buf_sel_o;
  logic [IW-1:0] layer_idx_o;
  logic          busy_o;
  logic          finish_o;
  logic          result_buf_o;
  logic          error_o;

  // Signals for the short-watchdog instance.
  logic          t_start;
  logic          t_abort;
  logic [IW:0]   t_num;
  logic          t_cfg_we;
  logic [IW-1:0] t_cfg_addr;
  logic [MW-1:0] t_cfg_mode;
  logic          t_acc_start;
  logic [MW-1:0] t_acc_mode;
  logic          t_acc_finish;
  logic          t_buf_sel;
  logic [IW-1:0] t_layer_idx;
  logic          t_busy;
  logic          t_finish;
  logic          t_result_buf;
  logic          t_error;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int t_fin_cnt = 0;

  typedef struct {
    bit          is_fin;
    logic [MW-1:0] mode;
    logic        bsel;
    logic [IW-1:0] idx;
    int          at;
  } ev_t;

  ev_t exp_q[$];
  logic [MW-1:0] tab_model [MAXL];

  layer_sequencer #(.MAX_LAYERS(MAXL), .MODE_W(MW), .TIMEOUT_W(20)) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .abort_i(abort_i),
    .num_layers_i(num_layers_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
    .cfg_mode_i(cfg_mode_i), .acc_start_o(acc_start_o), .acc_mode_o(acc_mode_o),
    .acc_finish_i(acc_finish_i), .buf_sel_o(buf_sel_o), .layer_idx_o(layer_idx_o),
    .busy_o(busy_o), .finish_o(finish_o), .result_buf_o(result_buf_o),
    .error_o(error_o)
  );

  layer_sequencer #(.MAX_LAYERS(MAXL), .MODE_W(MW), .TIMEOUT_W(4)) dut_wd (
    .clk(clk), .rstn(rstn), .start_i(t_start), .abort_i(t_abort),
    .num_layers_i(t_num), .cfg_we_i(t_cfg_we), .cfg_addr_i(t_cfg_addr),
    .cfg_mode_i(t_cfg_mode), .acc_start_o(t_acc_start), .acc_mode_o(t_acc_mode),
    .acc_finish_i(t_acc_finish), .buf_sel_o(t_buf_sel), .layer_idx_o(t_layer_idx),
    .busy_o(t_busy), .finish_o(t_finish), .result_buf_o(t_result_buf),
    .error_o(t_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every start pulse or completion pulse must match the next expectation.
  always @(negedge clk) begin
    if (rstn && (acc_start_o || finish_o)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {30'd0, acc_start_o, finish_o}, 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("ev_kind", {31'd0, finish_o}, {31'd0, e.is_fin});
        check("ev_cycle", cyc, e.at);
        if (e.is_fin) begin
          check("result_buf", {31'd0, result_buf_o}, {31'd0, e.bsel});
        end else begin
          check("acc_mode", {28'd0, acc_mode_o}, {28'd0, e.mode});
          check("buf_sel", {31'd0, buf_sel_o}, {31'd0, e.bsel});
          check("layer_idx", {28'd0, layer_idx_o}, {28'd0, e.idx});
        end
      end
    end
  end

  // Count completion pulses from the short-watchdog instance.
  always @(negedge clk) if (rstn && t_finish) t_fin_cnt++;

  task automatic step(input int m);
    repeat (m) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int addr, input int mode);
    cfg_we_i   = 1'b1;
    cfg_addr_i = IW'(addr);
    cfg_mode_i = MW'(mode);
    tab_model[addr] = MW'(mode);
    step(1);
    cfg_we_i = 1'b0;
  endtask

  // inj: 0 plain run, 1 cfg write + start while busy in layer 0,
  // 2 abort in WAIT of layer 1, 3 reset in WAIT of layer 2.
  task automatic run(input int n, input int k, input int inj);
    int c0;
    int stop_at;
    ev_t e;
    stop_at = (inj == 2) ? 1 : (inj == 3) ? 2 : n;
    c0 = cyc;
    start_i = 1'b1;
    num_layers_i = (IW+1)'(n);
    for (int i = 0; i < n && i <= stop_at; i++) begin
      e.is_fin = 1'b0;
      e.mode   = tab_model[i];
      e.bsel   = i[0];
      e.idx    = IW'(i);
      e.at     = c0 + 1 + i * (k + 2);
      exp_q.push_back(e);
    end
    if (inj < 2) begin
      e.is_fin = 1'b1;
      e.mode   = '0;
      e.bsel   = 1'(n - 1);
      e.idx    = '0;
      e.at     = c0 + n * (k + 2) + 1;
      exp_q.push_back(e);
    end
    step(1);
    start_i = 1'b0;
    check("err_clr_on_start", {31'd0, error_o}, 32'd0);
    for (int i = 0; i < n; i++) begin
      if (inj == 2 && i == 1) begin
        step(1);
        abort_i = 1'b1;
        step(1);
        abort_i = 1'b0;
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        check("abort_err", {31'd0, error_o}, 32'd0);
        return;
      end
      if (inj == 3 && i == 2) begin
        step(1);
        rstn = 1'b0;
        #1;
        check("rst_outputs",
              {22'd0, acc_start_o, acc_mode_o, buf_sel_o, layer_idx_o},
              32'd0);
        check("rst_flags", {28'd0, busy_o, finish_o, result_buf_o, error_o}, 32'd0);
        for (int j = 0; j < MAXL; j++) tab_model[j] = '0;
        step(1);
        rstn = 1'b1;
        return;
      end
      if (inj == 1 && i == 0) begin
        step(1);
        cfg_we_i   = 1'b1;
        cfg_addr_i = '0;
        cfg_mode_i = 4'd9;
        start_i    = 1'b1;
        num_layers_i = 5'd1;
        step(1);
        cfg_we_i = 1'b0;
        start_i  = 1'b0;
        step(k - 2);
      end else begin
        step(k);
      end
      acc_finish_i = 1'b1;
      step(1);
      acc_finish_i = 1'b0;
      step(1);
    end
    step(1);
  endtask

  initial begin
    rstn = 1'b0;
    start_i = 1'b0; abort_i = 1'b0; num_layers_i = '0;
    cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_mode_i = '0; acc_finish_i = 1'b0;
    t_start = 1'b0; t_abort = 1'b0; t_num = '0;
    t_cfg_we = 1'b0; t_cfg_addr = '0; t_cfg_mode = '0; t_acc_finish = 1'b0;
    for (int j = 0; j < MAXL; j++) tab_model[j] = '0;
    #2;
    check("reset_outputs", {22'd0, acc_start_o, acc_mode_o, buf_sel_o, layer_idx_o}, 32'd0);
    check("reset_flags", {28'd0, busy_o, finish_o, result_buf_o, error_o}, 32'd0);
    step(2);
    rstn = 1'b1;
    step(1);

    // Three-layer run, finish 4 cycles after each start.
    cfg_write(0, 3);
    cfg_write(1, 5);
    cfg_write(2, 7);
    run(3, 4, 0);
    check("idle_after_run", {31'd0, busy_o}, 32'd0);

    // Illegal counts go to ERR; a legal start then recovers.
    start_i = 1'b1; num_layers_i = 5'd0;
    step(1);
    start_i = 1'b0;
    check("err_zero", {30'd0, error_o, busy_o}, 32'd2);
    start_i = 1'b1; num_layers_i = 5'd17;
    step(1);
    start_i = 1'b0;
    check("err_17", {30'd0, error_o, busy_o}, 32'd2);
    run(1, 2, 0);
    check("err_cleared", {31'd0, error_o}, 32'd0);
    start_i = 1'b1; num_layers_i = 5'd0;
    step(1);
    start_i = 1'b0;
    abort_i = 1'b1;
    step(1);
    abort_i = 1'b0;
    check("abort_clears_err", {31'd0, error_o}, 32'd0);

    // Watchdog timeout on the 4-bit instance, then finish in the saturation cycle.
    t_start = 1'b1; t_num = 5'd1;
    step(1);
    t_start = 1'b0;
    check("wd_launch", {31'd0, t_acc_start}, 32'd1);
    step(16);
    check("wd_sat_cycle", {30'd0, t_error, t_busy}, 32'd1);
    step(1);
    check("wd_timeout", {30'd0, t_error, t_busy}, 32'd2);
    step(3);
    check("wd_no_finish", t_fin_cnt, 32'd0);
    t_start = 1'b1;
    step(1);
    t_start = 1'b0;
    step(16);
    t_acc_finish = 1'b1;
    step(1);
    t_acc_finish = 1'b0;
    check("wd_sat_finish_next", {30'd0, t_error, t_busy}, 32'd1);
    step(1);
    check("wd_sat_finish_done", {30'd0, t_finish, t_result_buf}, 32'd2);
    step(2);
    check("wd_finish_count", t_fin_cnt, 32'd1);

    // Abort in WAIT of layer 1 of 4; later finish is ignored; table preserved.
    run(4, 2, 2);
    acc_finish_i = 1'b1;
    step(1);
    acc_finish_i = 1'b0;
    step(2);
    check("stray_fin_after_abort", {31'd0, busy_o}, 32'd0);
    run(3, 1, 0);

    // Config write and start while busy are ignored; stray finish in IDLE too.
    run(2, 3, 1);
    acc_finish_i = 1'b1;
    step(1);
    acc_finish_i = 1'b0;
    step(2);
    check("stray_fin_idle", {31'd0, busy_o}, 32'd0);
    run(1, 1, 0);

    // Full-depth run, then a reset in the middle of a run.
    run(16, 1, 0);
    check("full_result_buf", {31'd0, result_buf_o}, 32'd1);
    run(16, 1, 3);
    step(1);
    run(1, 1, 0);

    step(4);
    check("sb_drain", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
